// File: rtl/gng_romload_pack.sv
// Packs the HPS byte-wide ROM download into 16-bit little-endian memory words through a
// 2-entry FIFO, and latches the ROM-set header signature that enables the Invulnerable option.
module gng_romload_pack #(
   parameter int unsigned AW = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   output logic          mem_req,
   output logic [AW-2:0] mem_addr,
   output logic [15:0]   mem_data,
   output logic [1:0]    mem_be,
   input  logic          mem_ack,
   output logic          inv_ena,
   output logic          done,
   output logic          overflow
);
   localparam int unsigned EW = (AW - 1) + 16 + 2;

   typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_t;

   state_t        r_state, w_state_d;
   logic          r_dl;
   logic [EW-1:0] r_fifo [2];
   logic [EW-1:0] w_fifo_d [2];
   logic [1:0]    r_cnt, w_cnt_d;
   logic          r_pend_v, w_pend_v_d;
   logic [EW-1:0] r_pend, w_pend_d;
   logic          r_part_v, w_part_v_d;
   logic [AW-2:0] r_part_a, w_part_a_d;
   logic [7:0]    r_part_d, w_part_d_d;
   logic [3:0]    r_hdr, w_hdr_d;
   logic          r_inv, w_inv_d;
   logic          r_ovf, w_ovf_d;

   logic          w_pop, w_oob, w_match;
   logic [AW-2:0] w_waddr;
   logic [7:0]    w_sig;
   logic [1:0]    w_nnew, w_nlist, w_cnt1, w_room, w_take;
   logic [EW-1:0] w_new0, w_new1, w_l0, w_l1, w_part_ent;

   assign mem_req                      = (r_cnt != 2'd0);
   assign {mem_addr, mem_data, mem_be} = r_fifo[0];
   // A pending second push holds the HPS off just like a full FIFO.
   assign ioctl_wait                   = (r_cnt == 2'd2) | r_pend_v;
   assign inv_ena                      = r_inv;
   assign overflow                     = r_ovf;

   assign w_pop      = mem_req & mem_ack;
   assign w_oob      = |ioctl_addr[24:AW];
   assign w_waddr    = ioctl_addr[AW-1:1];
   assign w_match    = r_part_v && (r_part_a == w_waddr);
   assign w_part_ent = {r_part_a, 8'h00, r_part_d, 2'b01};

   always_comb begin
      case (ioctl_addr[1:0])
         2'd0:    w_sig = 8'h10;
         2'd1:    w_sig = 8'h83;
         2'd2:    w_sig = 8'h00;
         default: w_sig = 8'h80;
      endcase
   end

   always_comb begin
      w_state_d  = r_state;
      done       = 1'b0;
      w_nnew     = 2'd0;
      w_new0     = '0;
      w_new1     = '0;
      w_part_v_d = r_part_v;
      w_part_a_d = r_part_a;
      w_part_d_d = r_part_d;
      w_hdr_d    = r_hdr;
      w_inv_d    = r_inv;
      w_ovf_d    = r_ovf;
      unique case (r_state)
         StIdle: begin
            if (ioctl_download && !r_dl) begin
               w_state_d = StLoad;
               w_hdr_d   = '0;
               w_ovf_d   = 1'b0;
            end
         end
         StLoad: begin
            if (!ioctl_download) begin
               w_state_d = StFlush;
               w_inv_d   = &r_hdr;
            end else if (ioctl_wr) begin
               if (w_oob || ioctl_wait) begin
                  w_ovf_d = 1'b1;
               end else begin
                  if (ioctl_addr[AW-1:2] == '0 && ioctl_dout == w_sig) begin
                     w_hdr_d[ioctl_addr[1:0]] = 1'b1;
                  end
                  w_part_v_d = 1'b0;
                  if (!ioctl_addr[0]) begin
                     w_part_v_d = 1'b1;
                     w_part_a_d = w_waddr;
                     w_part_d_d = ioctl_dout;
                     if (r_part_v) begin
                        w_nnew = 2'd1;
                        w_new0 = w_part_ent;
                     end
                  end else if (w_match) begin
                     w_nnew = 2'd1;
                     w_new0 = {w_waddr, ioctl_dout, r_part_d, 2'b11};
                  end else if (r_part_v) begin
                     w_nnew = 2'd2;
                     w_new0 = w_part_ent;
                     w_new1 = {w_waddr, ioctl_dout, 8'h00, 2'b10};
                  end else begin
                     w_nnew = 2'd1;
                     w_new0 = {w_waddr, ioctl_dout, 8'h00, 2'b10};
                  end
               end
            end
         end
         StFlush: begin
            if (r_part_v) begin
               w_nnew     = 2'd1;
               w_new0     = w_part_ent;
               w_part_v_d = 1'b0;
            end else if (r_cnt == 2'd0 && !r_pend_v) begin
               w_state_d = StIdle;
               done      = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Pending entry goes first; whatever does not fit after this cycle's pop waits in r_pend.
   always_comb begin
      w_l0        = r_pend_v ? r_pend : w_new0;
      w_l1        = r_pend_v ? w_new0 : w_new1;
      w_nlist     = w_nnew + {1'b0, r_pend_v};
      w_cnt1      = r_cnt - {1'b0, w_pop};
      w_room      = 2'd2 - w_cnt1;
      w_take      = (w_nlist < w_room) ? w_nlist : w_room;
      w_fifo_d[0] = w_pop ? r_fifo[1] : r_fifo[0];
      w_fifo_d[1] = r_fifo[1];
      if (w_cnt1 == 2'd0) begin
         if (w_take != 2'd0) w_fifo_d[0] = w_l0;
         if (w_take == 2'd2) w_fifo_d[1] = w_l1;
      end else if (w_cnt1 == 2'd1 && w_take != 2'd0) begin
         w_fifo_d[1] = w_l0;
      end
      w_cnt_d    = w_cnt1 + w_take;
      w_pend_v_d = (w_nlist > w_take);
      w_pend_d   = (w_take == 2'd0) ? w_l0 : w_l1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_dl      <= 1'b0;
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_cnt     <= 2'd0;
         r_pend_v  <= 1'b0;
         r_pend    <= '0;
         r_part_v  <= 1'b0;
         r_part_a  <= '0;
         r_part_d  <= 8'h00;
         r_hdr     <= 4'h0;
         r_inv     <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_dl      <= ioctl_download;
         r_fifo[0] <= w_fifo_d[0];
         r_fifo[1] <= w_fifo_d[1];
         r_cnt     <= w_cnt_d;
         r_pend_v  <= w_pend_v_d;
         r_pend    <= w_pend_d;
         r_part_v  <= w_part_v_d;
         r_part_a  <= w_part_a_d;
         r_part_d  <= w_part_d_d;
         r_hdr     <= w_hdr_d;
         r_inv     <= w_inv_d;
         r_ovf     <= w_ovf_d;
      end
   end

endmodule

// File: tb/tb_gng_romload_pack.sv
// Self-checking bench for gng_romload_pack: directed cases plus random downloads scored against
// a byte-stream-to-word reference model.
module tb_gng_romload_pack;
   localparam int unsigned AW = 19;
   localparam logic [7:0] SIG [4] = '{8'h10, 8'h83, 8'h00, 8'h80};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ioctl_download = 1'b0;
   logic          ioctl_wr = 1'b0;
   logic [24:0]   ioctl_addr = '0;
   logic [7:0]    ioctl_dout = '0;
   logic          ioctl_wait;
   logic          mem_req;
   logic [AW-2:0] mem_addr;
   logic [15:0]   mem_data;
   logic [1:0]    mem_be;
   logic          mem_ack = 1'b0;
   logic          inv_ena;
   logic          done;
   logic          overflow;

   gng_romload_pack #(.AW(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_be         (mem_be),
      .mem_ack        (mem_ack),
      .inv_ena        (inv_ena),
      .done           (done),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            ack_pct = 0;
   int            done_cnt = 0;
   int            done_base = 0;
   logic [24:0]   q_a[$];
   logic [7:0]    q_d[$];
   logic [35:0]   exp_q[$];
   logic [35:0]   got_log[$];
   logic          held_v = 1'b0;
   logic [17:0]   held_a = '0;
   logic [7:0]    held_d = '0;
   logic [3:0]    hdr = '0;
   logic          exp_ovf = 1'b0;
   logic          exp_inv = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [35:0] got_at(input int i);
      return (i < got_log.size()) ? got_log[i] : '1;
   endfunction

   // Reference model: pair each even byte with the following odd byte of the same word.
   task automatic emit(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
      exp_q.push_back({a, d, be});
   endtask

   task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
      logic [17:0] wa;
      if (a >= (25'd1 << AW)) begin
         exp_ovf = 1'b1;
         return;
      end
      wa = a[AW-1:1];
      if (a < 25'd4 && d == SIG[a[1:0]]) hdr[a[1:0]] = 1'b1;
      if (!a[0]) begin
         if (held_v) emit(held_a, {8'h00, held_d}, 2'b01);
         held_v = 1'b1;
         held_a = wa;
         held_d = d;
      end else if (held_v && held_a == wa) begin
         emit(wa, {d, held_d}, 2'b11);
         held_v = 1'b0;
      end else begin
         if (held_v) emit(held_a, {8'h00, held_d}, 2'b01);
         held_v = 1'b0;
         emit(wa, {d, 8'h00}, 2'b10);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (mem_req && mem_ack) begin
            got_log.push_back({mem_addr, mem_data, mem_be});
            check("word_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("word", {mem_addr, mem_data, mem_be}, exp_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #2;
         mem_ack = ($urandom_range(0, 99) < ack_pct);
      end
   end

   task automatic start_dl();
      exp_q.delete();
      got_log.delete();
      held_v    = 1'b0;
      hdr       = '0;
      exp_ovf   = 1'b0;
      done_base = done_cnt;
      ioctl_download = 1'b1;
      step();
      step();
      check("inv_hold", inv_ena, exp_inv);
      check("ovf_clr", overflow, 0);
   endtask

   task automatic strobe_m(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      model_byte(a, d);
      step();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      int t = 0;
      while (ioctl_wait && t < 300) begin
         step();
         t++;
      end
      ok = !ioctl_wait;
      if (!ok) check("wait_timeout", ioctl_wait, 0);
   endtask

   task automatic end_dl();
      int t = 0;
      ioctl_download = 1'b0;
      if (held_v) emit(held_a, {8'h00, held_d}, 2'b01);
      held_v  = 1'b0;
      exp_inv = &hdr;
      while (done_cnt == done_base && t < 1000) begin
         step();
         t++;
      end
      check("done_seen", 64'(done_cnt != done_base), 64'd1);
      repeat (3) step();
      check("done_once", 64'(done_cnt - done_base), 64'd1);
      check("drained", 64'(exp_q.size()), 64'd0);
      check("inv_ena", inv_ena, exp_inv);
      check("overflow", overflow, exp_ovf);
      check("req_low", mem_req, 0);
   endtask

   task automatic run_dl(input int stall_at, input bit inject, input int gap);
      bit ok;
      start_dl();
      foreach (q_a[i]) begin
         if (i == stall_at) begin
            repeat (4) step();
            check("wait_full", ioctl_wait, 1);
            check("req_full", mem_req, 1);
            check("ovf_pre", overflow, 0);
            if (inject) begin
               ioctl_addr = 25'd10;
               ioctl_dout = 8'h55;
               ioctl_wr   = 1'b1;
               exp_ovf    = 1'b1;
               step();
               ioctl_wr = 1'b0;
            end
            ack_pct = 100;
         end
         wait_ready(ok);
         if (!ok) break;
         strobe_m(q_a[i], q_d[i]);
         repeat ($urandom_range(0, gap)) step();
      end
      end_dl();
   endtask

   task automatic load_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input int n);
      logic [7:0] b [6];
      b = '{b0, b1, b2, b3, b4, b5};
      q_a.delete();
      q_d.delete();
      for (int i = 0; i < n; i++) begin
         q_a.push_back(25'(i));
         q_d.push_back(b[i]);
      end
   endtask

   task automatic build_random();
      int n, a, r;
      bit use_sig;
      q_a.delete();
      q_d.delete();
      n       = $urandom_range(10, 40);
      a       = $urandom_range(0, 1) ? 0 : $urandom_range(0, 40);
      use_sig = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            q_a.push_back(25'((1 << AW) + $urandom_range(0, 100)));
            q_d.push_back(8'($urandom));
         end else begin
            if (r < 20) a = $urandom_range(0, 63);
            q_a.push_back(25'(a));
            q_d.push_back((a < 4 && use_sig) ? SIG[a] : 8'($urandom));
            a++;
         end
      end
   endtask

   initial begin
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_req", mem_req, 0);
      check("rst_wait", ioctl_wait, 0);
      check("rst_inv", inv_ena, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_head", {mem_addr, mem_data, mem_be}, 0);

      // Valid header, ack every cycle.
      ack_pct = 100;
      load_seq(8'h10, 8'h83, 8'h00, 8'h80, 8'hAA, 8'hBB, 6);
      run_dl(-1, 1'b0, 0);
      check("t1_w0", got_at(0), {18'd0, 16'h8310, 2'b11});
      check("t1_w1", got_at(1), {18'd1, 16'h8000, 2'b11});
      check("t1_w2", got_at(2), {18'd2, 16'hBBAA, 2'b11});

      // Reset with two words queued and the FIFO full.
      ack_pct = 0;
      start_dl();
      for (int i = 0; i < 4; i++) strobe_m(25'(i), 8'($urandom));
      step();
      step();
      check("t6_req", mem_req, 1);
      check("t6_wait", ioctl_wait, 1);
      rst = 1'b1;
      #1;
      check("t6_req0", mem_req, 0);
      check("t6_wait0", ioctl_wait, 0);
      check("t6_inv0", inv_ena, 0);
      check("t6_done0", done, 0);
      check("t6_ovf0", overflow, 0);
      check("t6_head0", {mem_addr, mem_data, mem_be}, 0);
      ioctl_download = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
      held_v  = 1'b0;
      exp_inv = 1'b0;
      step();
      check("t6_nodone", 64'(done_cnt - done_base), 64'd0);

      // Bad header byte 3.
      ack_pct = 100;
      load_seq(8'h10, 8'h83, 8'h00, 8'h81, 8'hAA, 8'hBB, 6);
      run_dl(-1, 1'b0, 0);
      check("t2_w1", got_at(1), {18'd1, 16'h8100, 2'b11});

      // Ack held low: back-pressure, then drain; second pass also strobes into a full FIFO.
      ack_pct = 0;
      load_seq(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 6);
      run_dl(4, 1'b0, 0);
      ack_pct = 0;
      run_dl(4, 1'b1, 0);

      // Three bytes, partial flushed on download end.
      ack_pct = 100;
      load_seq(8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 3);
      run_dl(-1, 1'b0, 0);
      check("t4_w0", got_at(0), {18'd0, 16'hB2A1, 2'b11});
      check("t4_w1", got_at(1), {18'd1, 16'h00C3, 2'b01});

      // Lone odd byte, then an out-of-range address.
      ack_pct = 0;
      start_dl();
      strobe_m(25'd7, 8'h5A);
      check("t5_req", mem_req, 1);
      check("t5_head", {mem_addr, mem_data, mem_be}, {18'd3, 16'h5A00, 2'b10});
      ack_pct = 100;
      step();
      strobe_m(25'(1 << AW), 8'h11);
      end_dl();

      for (int k = 0; k < 8; k++) begin
         build_random();
         ack_pct = $urandom_range(30, 100);
         run_dl(-1, 1'b0, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gng_romload_pack.md
# gng_romload_pack

Packs the byte-wide ROM download stream from the HPS (`ioctl_*`) into 16-bit little-endian words for the ROM/SDRAM write port. It also detects the ROM-set header signature that enables the Invulnerable option. It sits between `hps_io` and the game's ROM storage, and replaces the direct byte write path. It flow-controls the HPS through `ioctl_wait` when the memory side stalls.

## Interface
Parameters:
- AW, 19, byte-address width kept from `ioctl_addr`; the memory word address is AW-1 bits.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ioctl_download  in  1  high while a download is in progress.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  high when the FIFO is full; the HPS holds the next strobe while it is high.
- mem_req  out  1  high while a word is presented.
- mem_addr  out  AW-1  word address, equal to byte address >> 1.
- mem_data  out  16  word data; the even-address byte is in [7:0].
- mem_be  out  2  byte enables; [0] is the low byte.
- mem_ack  in  1  one-cycle accept, sampled only while mem_req is high.
- inv_ena  out  1  header signature matched on the last completed download.
- done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky error flag; cleared only by rst or the start of a new download.

## Operation
- State machine: IDLE -> LOAD on the rising edge of ioctl_download. LOAD -> FLUSH on its falling edge. FLUSH -> IDLE once the FIFO is empty and no partial byte remains; the transition fires `done` for one cycle.
- IDLE -> LOAD clears the header flags and `overflow`. `inv_ena` holds its previous value during LOAD.
- Partial register: it holds one even-address byte together with its word address and a valid bit.
- Each ioctl_wr accepted in LOAD is handled by its address:
  - addr >= 2^AW: the byte is dropped and `overflow` is set.
  - Even address, partial empty: the byte is latched into the partial register.
  - Even address, partial valid: the partial is pushed with be=01, then the new byte is latched.
  - Odd address whose word address matches the partial: the word {new, partial} is pushed with be=11 and the partial is cleared.
  - Odd address, no match: any valid partial is pushed first with be=01, then {new, 8'h00} is pushed with be=10.
- A case that needs two pushes with only one free FIFO slot takes two cycles. `ioctl_wait` is asserted for that cycle.
- On entry to FLUSH, a valid partial is pushed with be=01.
- FIFO: 2 entries of {addr, data, be}.
  - `mem_req` = FIFO not empty. `mem_addr`, `mem_data` and `mem_be` show the head entry.
  - `mem_ack` pops the head.
  - A push and a pop in the same cycle are both honoured.
- `ioctl_wait` = FIFO count is 2.
- A strobe that arrives while the FIFO is full, after the wait was raised, is dropped and sets `overflow`. It must never corrupt the FIFO.
- ioctl_wr outside LOAD is ignored.
- Header detection: flags f0..f3 are set when the bytes at addresses 0..3 equal 10, 83, 00, 80 hex. On LOAD -> FLUSH, `inv_ena` <= &f. A download with no writes to addresses 0..3 therefore yields 0.
- Reset mid-download: all state returns to its reset value immediately. The FIFO and partial are discarded. No `done` pulse is produced.

## Timing
- Reset values: `mem_req`=0, `ioctl_wait`=0, `inv_ena`=0, `done`=0, `overflow`=0, `mem_be`=00, `mem_addr`=0, `mem_data`=0. State = IDLE, FIFO empty.
- An odd strobe in cycle N that completes a word: `mem_req` is high in cycle N+1 with that word at the head.
- An ack in cycle M pops the head. If a second entry exists it is presented in M+1 with `mem_req` still high; otherwise `mem_req` is low in M+1.
- `ioctl_wait` rises in the cycle after the push that fills the FIFO. It falls in the cycle after the pop.
- Download falling edge in cycle K:
  - With a valid partial and an empty FIFO, the partial is presented in cycle K+2.
  - With an empty FIFO and no partial, `done` pulses in cycle K+1.
- `inv_ena` updates in the cycle after the falling edge of `ioctl_download` is detected.

## Test plan
- Write bytes 10,83,00,80,AA,BB to addresses 0-5, ack every cycle -> words 8310/be=11 at address 0, 8000 at 1, BBAA at 2; `inv_ena`=1 after download; a single `done` pulse.
- Same sequence with byte 3 = 81 -> the same words with 8100 at address 1; `inv_ena`=0.
- Six bytes written back-to-back with `mem_ack` held low -> `ioctl_wait`=1 after the second word; holding strobes gives no loss; releasing ack drains all words in order; `overflow`=0.
- Three bytes written to addresses 0..2, then download drops -> words at address 0 (be=11) and at address 1 with data 00xx and be=01; `done` follows the last ack.
- Addr 7 alone (odd, no partial) -> word address 3, data {byte,00}, be=10. Then a byte at address 2^AW -> dropped, `overflow`=1.
- Assert `rst` while `mem_req`=1 with two entries queued -> all outputs return to their reset values in the same cycle; no `done` pulse; the next download starts cleanly.
